pbuf_axis_framer: RTL and testbench
===================================

Name: pbuf_axis_framer

Overview:
- Consumes the ping-pong buffer read stream: a data-enable strobe plus data word, no backpressure.
- Packs each C_FRAME_LEN-word block into an AXI4-Stream frame, with tlast on the final word.
- A synchronous FIFO absorbs downstream tready stalls.
- Throttles the upstream buffer via a read-ready level that changes only on frame boundaries, so the buffer's read sequence is never cut mid-block.

Parameters:
- C_DATA_WIDTH, 32, data word width.
- C_FRAME_LEN, 20, words per frame; equals the ping-pong bank fill count; range 2..65535.
- C_FIFO_AW, 7, FIFO address width; depth = 2^C_FIFO_AW = 128.
- C_HEADROOM, 32, free entries required to keep O_rReady high; must be >= C_FRAME_LEN+4.

Ports:
- I_clk  in  1  clock.
- I_rst  in  1  asynchronous, active-high reset.
- O_rReady  out  1  read enable to the upstream ping-pong buffer.
- I_rDataEn  in  1  upstream word valid.
- I_rData  in  C_DATA_WIDTH  upstream word.
- O_tvalid  out  1  AXI-Stream valid.
- I_tready  in  1  AXI-Stream ready.
- O_tdata  out  C_DATA_WIDTH  AXI-Stream data.
- O_tlast  out  1  last word of frame.
- I_clrErr  in  1  single-cycle pulse; clears O_overflow.
- O_overflow  out  1  sticky: a word was dropped.
- O_frameCnt  out  16  frames fully transferred downstream; wraps.
- O_level  out  C_FIFO_AW+1  current FIFO occupancy.

Behaviour:
- Reset (async assert, sync release): all outputs 0 (O_rReady, O_tvalid, O_tdata, O_tlast, O_overflow, O_frameCnt, O_level); FIFO pointers, word counter and state cleared.
  - Reset mid-frame discards all buffered and partial frames.
  - After release, the next accepted word starts a new frame at word index 0.
- Word counter wIdx, 16 bit:
  - Advances on every I_rDataEn, whether the word is stored or dropped, so frame alignment tracks upstream.
  - Wraps from C_FRAME_LEN-1 to 0.
  - The stored entry is {last, data}, with last = (wIdx == C_FRAME_LEN-1).
- FIFO write: on I_rDataEn when O_level < 2^C_FIFO_AW, or when a pop occurs in the same cycle (simultaneous push+pop at full is accepted; level unchanged).
  - Otherwise the word is dropped and O_overflow is set the next cycle.
  - O_overflow holds until an I_clrErr pulse. If I_clrErr and a new drop coincide, the flag stays set.
- Output stage: first-word-fall-through register.
  - A word pushed into an empty FIFO at edge N gives O_tvalid=1 with that word after edge N+2.
  - Pop occurs on O_tvalid && I_tready.
  - While O_tvalid && !I_tready, O_tdata and O_tlast are held stable.
  - Back-to-back pops at 1 word/cycle sustain full throughput.
  - When empty, O_tvalid=0 and O_tdata/O_tlast hold their last values.
- O_level: registered count of entries, including the output register; updated the cycle after push/pop.
- O_frameCnt: increments on a handshake with O_tlast=1.
- Read-ready FSM, states HOLD and RUN:
  - HOLD: O_rReady=0. Go to RUN when free = 2^C_FIFO_AW - O_level >= C_HEADROOM.
  - RUN: O_rReady=1. Go to HOLD only when free < C_HEADROOM, wIdx==0 and I_rDataEn==0 in that cycle (frame boundary). Otherwise stay in RUN.
  - The headroom rule guarantees the remaining words of an in-progress frame plus pipeline slack always fit, so no overflow occurs under legal parameters.
- FIFO storage: inferred simple dual-port RAM, C_DATA_WIDTH+1 bits wide.
- Pointers: C_FIFO_AW+1 bits, natural wrap.

Test Plan:
- Reset, then 20 consecutive I_rDataEn words 0x100..0x113 with I_tready=1 -> O_tvalid first after 2 cycles; 20 beats 0x100..0x113; O_tlast only on 0x113; O_frameCnt=1; O_level returns to 0.
- I_tready=0 for 200 cycles while 5 frames are offered -> O_rReady drops at a frame boundary once free<32; no word lost; O_overflow=0; after I_tready=1, 100 beats out in order with tlast every 20th; O_frameCnt=5.
- Random I_tready (50%), 1000 frames of incrementing data -> output sequence matches input exactly; O_frameCnt=1000 (mod 65536 = 1000).
- Force I_rDataEn with O_rReady ignored and I_tready=0 until 130 words -> words 129,130 dropped; O_overflow=1; wIdx still aligned (tlast on word 120); I_clrErr pulse -> O_overflow=0.
- Assert I_rst at word 7 of a frame with 3 words buffered -> all outputs 0 immediately; the next frame after release has tlast on its 20th word.
- Push and pop in the same cycle at O_level=128 -> word accepted; O_level stays 128; no overflow.

Source files
------------

// File: rtl/pbuf_axis_framer.sv
// pbuf_axis_framer: turns the ping-pong buffer read stream into AXI4-Stream
// frames of C_FRAME_LEN words. A FIFO with a two-stage FWFT output absorbs
// tready stalls, and the upstream read-ready level only changes on frame
// boundaries.
module pbuf_axis_framer #(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_FRAME_LEN  = 20,
  parameter int C_FIFO_AW    = 7,
  parameter int C_HEADROOM   = 32
) (
  input  logic                    I_clk,
  input  logic                    I_rst,
  output logic                    O_rReady,
  input  logic                    I_rDataEn,
  input  logic [C_DATA_WIDTH-1:0] I_rData,
  output logic                    O_tvalid,
  input  logic                    I_tready,
  output logic [C_DATA_WIDTH-1:0] O_tdata,
  output logic                    O_tlast,
  input  logic                    I_clrErr,
  output logic                    O_overflow,
  output logic [15:0]             O_frameCnt,
  output logic [C_FIFO_AW:0]      O_level
);

  localparam int unsigned       DEPTH      = 2 ** C_FIFO_AW;
  localparam int                EW         = C_DATA_WIDTH + 1;
  localparam int                LAST       = C_FRAME_LEN - 1;
  localparam logic [C_FIFO_AW:0] DEPTH_L    = DEPTH[C_FIFO_AW:0];
  localparam logic [C_FIFO_AW:0] HEADROOM_L = C_HEADROOM[C_FIFO_AW:0];
  localparam logic [15:0]       LAST_IDX   = LAST[15:0];

  localparam logic [0:0] ST_HOLD = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Storage: entry = {last, data}
  logic [EW-1:0] mem [DEPTH];

  logic [C_FIFO_AW:0] wr_ptr_q, wr_ptr_d;
  logic [C_FIFO_AW:0] rd_ptr_q, rd_ptr_d;
  logic [C_FIFO_AW:0] level_q, level_d;
  logic [15:0]        widx_q, widx_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;
  logic               mid_valid_q, mid_valid_d;
  logic [EW-1:0]      mid_entry_q;
  logic               out_valid_q, out_valid_d;
  logic [EW-1:0]      out_entry_q, out_entry_d;
  logic               overflow_q, overflow_d;
  logic [0:0]         state_q, state_d;

  logic               pop, push, drop, full, ram_empty, mid_move, ram_rd;
  logic [C_FIFO_AW:0] free_cnt;
  logic [EW-1:0]      wr_entry;
  logic [C_FIFO_AW-1:0] wr_addr, rd_addr;

  // Handshake and flow decisions for this cycle
  always_comb begin
    pop       = out_valid_q && I_tready;
    full      = (level_q == DEPTH_L);
    // A pop frees a slot in the same cycle, so a full FIFO still takes a word.
    push      = I_rDataEn && (!full || pop);
    drop      = I_rDataEn && !push;
    ram_empty = (wr_ptr_q == rd_ptr_q);
    mid_move  = mid_valid_q && (!out_valid_q || pop);
    ram_rd    = !ram_empty && (!mid_valid_q || mid_move);
    wr_entry  = {(widx_q == LAST_IDX), I_rData};
    wr_addr   = wr_ptr_q[C_FIFO_AW-1:0];
    rd_addr   = rd_ptr_q[C_FIFO_AW-1:0];
    free_cnt  = DEPTH_L - level_q;
  end

  // Next-state for pointers, output pipeline, counters and flags
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d    = wr_ptr_q + {{C_FIFO_AW{1'b0}}, push};
    rd_ptr_d    = rd_ptr_q + {{C_FIFO_AW{1'b0}}, ram_rd};
    mid_valid_d = mid_valid_q;
    out_valid_d = out_valid_q;
    out_entry_d = out_entry_q;
    level_d     = level_q;
    widx_d      = widx_q;
    overflow_d  = overflow_q;
    frame_cnt_d = frame_cnt_q + {15'd0, pop && out_entry_q[C_DATA_WIDTH]};

    if (ram_rd) begin
      mid_valid_d = 1'b1;
    end else if (mid_move) begin
      mid_valid_d = 1'b0;
    end

    // Output register refills from the mid stage; when empty it keeps the
    // last word so tdata/tlast stay put.
    if (mid_move) begin
      out_valid_d = 1'b1;
      out_entry_d = mid_entry_q;
    end else if (pop) begin
      out_valid_d = 1'b0;
    end

    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (pop && !push) begin
      level_d = level_q - 1'b1;
    end

    // Counts dropped words too, so frame alignment follows the upstream.
    if (I_rDataEn) begin
      widx_d = (widx_q == LAST_IDX) ? 16'd0 : widx_q + 16'd1;
    end

    if (drop) begin
      overflow_d = 1'b1;
    end else if (I_clrErr) begin
      overflow_d = 1'b0;
    end
  end

  // Read-ready FSM: only leaves RUN between frames
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HOLD: if (free_cnt >= HEADROOM_L) state_d = ST_RUN;
      ST_RUN:  if (free_cnt < HEADROOM_L && widx_q == 16'd0 && !I_rDataEn) state_d = ST_HOLD;
      default: state_d = ST_HOLD;
    endcase
  end

  // State registers
  always_ff @(posedge I_clk or posedge I_rst) begin
    // NOTE: sequential state uses non-blocking (<=) so all flops update from pre-edge values.
    if (I_rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      widx_q      <= '0;
      frame_cnt_q <= '0;
      mid_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_entry_q <= '0;
      overflow_q  <= 1'b0;
      state_q     <= ST_HOLD;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      widx_q      <= widx_d;
      frame_cnt_q <= frame_cnt_d;
      mid_valid_q <= mid_valid_d;
      out_valid_q <= out_valid_d;
      out_entry_q <= out_entry_d;
      overflow_q  <= overflow_d;
      state_q     <= state_d;
    end
  end

  // Dual-port RAM with registered read into the mid stage; the read address
  // never equals a live write address because the level caps occupancy.
  always_ff @(posedge I_clk) begin
    // NOTE: the RAM and its read register are not reset; valid flags guard their contents.
    if (push) mem[wr_addr] <= wr_entry;
    if (ram_rd) mid_entry_q <= mem[rd_addr];
  end

  assign O_rReady   = (state_q == ST_RUN);
  assign O_tvalid   = out_valid_q;
  assign O_tdata    = out_entry_q[C_DATA_WIDTH-1:0];
  assign O_tlast    = out_entry_q[C_DATA_WIDTH];
  assign O_overflow = overflow_q;
  assign O_frameCnt = frame_cnt_q;
  assign O_level    = level_q;

endmodule

// File: tb/tb_pbuf_axis_framer.sv
// Directed bench for pbuf_axis_framer: latency, stall/throttle, random
// backpressure, overflow, reset mid-frame and push+pop at full.
module tb_pbuf_axis_framer;

  localparam int DW = 32;
  localparam int FL = 20;

  logic          I_clk = 1'b0;
  logic          I_rst = 1'b0;
  logic          I_rDataEn = 1'b0;
  logic [DW-1:0] I_rData = '0;
  logic          I_tready = 1'b0;
  logic          I_clrErr = 1'b0;
  logic          O_rReady, O_tvalid, O_tlast, O_overflow;
  logic [DW-1:0] O_tdata;
  logic [15:0]   O_frameCnt;
  logic [7:0]    O_level;

  int n_checks = 0;
  int n_fail   = 0;
  int rr_mid_low = 0;
  logic [DW:0] exp_q [$];

  pbuf_axis_framer #(
    .C_DATA_WIDTH(DW), .C_FRAME_LEN(FL), .C_FIFO_AW(7), .C_HEADROOM(32)
  ) dut (
    .I_clk(I_clk), .I_rst(I_rst), .O_rReady(O_rReady),
    .I_rDataEn(I_rDataEn), .I_rData(I_rData),
    .O_tvalid(O_tvalid), .I_tready(I_tready), .O_tdata(O_tdata), .O_tlast(O_tlast),
    .I_clrErr(I_clrErr), .O_overflow(O_overflow),
    .O_frameCnt(O_frameCnt), .O_level(O_level)
  );

  always #5 I_clk = ~I_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, pass the edge, land 1 time unit after it.
  task automatic step(input logic en, input logic [DW-1:0] d, input logic rdy);
    I_rDataEn = en;
    I_rData   = d;
    I_tready  = rdy;
    @(posedge I_clk);
    #1;
  endtask

  function automatic logic rdy_of(input int mode);
    if (mode == 2) return logic'($urandom_range(0, 1));
    return (mode == 1);
  endfunction

  task automatic do_reset();
    I_rDataEn = 1'b0;
    I_tready  = 1'b0;
    I_clrErr  = 1'b0;
    I_rst     = 1'b1;
    repeat (2) @(posedge I_clk);
    #1;
    exp_q.delete();
    I_rst = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rready"},   O_rReady,   0);
    check({tag, "_tvalid"},   O_tvalid,   0);
    check({tag, "_tdata"},    O_tdata,    0);
    check({tag, "_tlast"},    O_tlast,    0);
    check({tag, "_overflow"}, O_overflow, 0);
    check({tag, "_framecnt"}, O_frameCnt, 0);
    check({tag, "_level"},    O_level,    0);
  endtask

  task automatic wait_ready(input int mode);
    int n = 0;
    while (!O_rReady && n < 500) begin
      step(1'b0, '0, rdy_of(mode));
      n++;
    end
    check("rready_wait", O_rReady, 1);
  endtask

  // Upstream model: idle gap, wait for read-ready, then the whole block.
  task automatic send_frame(input logic [DW-1:0] base, input int mode);
    step(1'b0, '0, rdy_of(mode));
    wait_ready(mode);
    for (int i = 0; i < FL; i++) begin
      if (i > 0 && !O_rReady) rr_mid_low++;
      exp_q.push_back({(i == FL - 1), base + DW'(i)});
      step(1'b1, base + DW'(i), rdy_of(mode));
    end
  endtask

  task automatic drain(input int mode);
    int n = 0;
    while ((exp_q.size() != 0 || O_tvalid) && n < 5000) begin
      step(1'b0, '0, rdy_of(mode));
      n++;
    end
    repeat (2) step(1'b0, '0, rdy_of(mode));
    check("drain_empty", exp_q.size(), 0);
  endtask

  // Scoreboard: every handshake must match the next expected {last, data}
  always @(negedge I_clk) begin
    if (!I_rst && O_tvalid && I_tready) begin
      check("beat_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        logic [DW:0] e;
        e = exp_q.pop_front();
        check("beat", {O_tlast, O_tdata}, e);
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- Reset values
    #1;
    I_rst = 1'b1;
    #2;
    check_all_zero("reset");
    do_reset();

    // ---- Single frame with tready=1, two-cycle first-word latency
    wait_ready(1);
    for (int i = 0; i < FL; i++) begin
      exp_q.push_back({(i == FL - 1), 32'h100 + 32'(i)});
      step(1'b1, 32'h100 + 32'(i), 1'b1);
      if (i == 0) check("lat_edge0_tvalid", O_tvalid, 0);
      if (i == 1) check("lat_edge1_tvalid", O_tvalid, 0);
      if (i == 2) begin
        check("lat_edge2_tvalid", O_tvalid, 1);
        check("lat_edge2_tdata", O_tdata, 32'h100);
        check("lat_edge2_tlast", O_tlast, 0);
      end
    end
    drain(1);
    check("t1_framecnt", O_frameCnt, 1);
    check("t1_level", O_level, 0);

    // ---- Stall: 5 frames into a blocked sink, rReady drops at the boundary
    do_reset();
    for (int f = 0; f < 5; f++) send_frame(32'h2000_0000 + 32'(f * FL), 0);
    check("t2_rready_after_last_word", O_rReady, 1);
    step(1'b0, '0, 1'b0);
    check("t2_rready_dropped", O_rReady, 0);
    repeat (80) step(1'b0, '0, 1'b0);
    check("t2_rready_held", O_rReady, 0);
    check("t2_level", O_level, 100);
    check("t2_overflow", O_overflow, 0);
    check("t2_tvalid_stalled", O_tvalid, 1);
    check("t2_tdata_stalled", O_tdata, 32'h2000_0000);
    drain(1);
    check("t2_framecnt", O_frameCnt, 5);
    check("t2_level_empty", O_level, 0);
    check("t2_rready_back", O_rReady, 1);
    check("t2_rready_mid_frame", rr_mid_low, 0);

    // ---- Forced overflow, coinciding clear, push+pop at full, alignment
    do_reset();
    for (int i = 0; i < 128; i++) begin
      exp_q.push_back({((i % FL) == FL - 1), 32'h4000_0000 + 32'(i)});
      step(1'b1, 32'h4000_0000 + 32'(i), 1'b0);
    end
    check("t4_level_full", O_level, 128);
    check("t4_no_overflow_yet", O_overflow, 0);
    step(1'b1, 32'h4000_0000 + 32'd128, 1'b0);
    check("t4_overflow_set", O_overflow, 1);
    I_clrErr = 1'b1;
    step(1'b1, 32'h4000_0000 + 32'd129, 1'b0);
    check("t4_clr_with_drop", O_overflow, 1);
    step(1'b0, '0, 1'b0);
    I_clrErr = 1'b0;
    check("t4_overflow_cleared", O_overflow, 0);
    check("t4_level_still_full", O_level, 128);
    // word 131, index 130 -> frame position 10
    exp_q.push_back({1'b0, 32'h4000_0000 + 32'd130});
    step(1'b1, 32'h4000_0000 + 32'd130, 1'b1);
    check("t6_pushpop_level", O_level, 128);
    check("t6_pushpop_overflow", O_overflow, 0);
    drain(1);
    for (int i = 131; i < 140; i++) begin
      exp_q.push_back({(i == 139), 32'h4000_0000 + 32'(i)});
      step(1'b1, 32'h4000_0000 + 32'(i), 1'b1);
    end
    drain(1);
    check("t4_framecnt", O_frameCnt, 7);
    check("t4_level_empty", O_level, 0);
    check("t4_overflow_end", O_overflow, 0);

    // ---- Reset at word 7 with 3 words buffered
    do_reset();
    wait_ready(1);
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back({1'b0, 32'h5000_0000 + 32'(i)});
      step(1'b1, 32'h5000_0000 + 32'(i), 1'b1);
    end
    check("t5_level_before_rst", O_level, 3);
    check("t5_pending_before_rst", exp_q.size(), 3);
    check("t5_tvalid_before_rst", O_tvalid, 1);
    I_rDataEn = 1'b0;
    I_rst = 1'b1;
    #1;
    check_all_zero("t5_rst");
    exp_q.delete();
    @(posedge I_clk);
    #1;
    I_rst = 1'b0;
    wait_ready(1);
    for (int i = 0; i < FL; i++) begin
      exp_q.push_back({(i == FL - 1), 32'h5100_0000 + 32'(i)});
      step(1'b1, 32'h5100_0000 + 32'(i), 1'b1);
    end
    drain(1);
    check("t5_framecnt", O_frameCnt, 1);

    // ---- Random backpressure, 1000 frames
    do_reset();
    rr_mid_low = 0;
    for (int f = 0; f < 1000; f++) send_frame(32'h3000_0000 + 32'(f * FL), 2);
    drain(2);
    check("t3_framecnt", O_frameCnt, 16'd1000);
    check("t3_overflow", O_overflow, 0);
    check("t3_level", O_level, 0);
    check("t3_rready_mid_frame", rr_mid_low, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
